// File: rtl/coin_credit_sequencer_if.sv
// Request/credit bundle between the input decode logic (master) and the
// coin credit sequencer (slave).
interface coin_credit_sequencer_if #(
  parameter int NREQ = 6
) ();
  logic [NREQ-1:0] req;
  logic            enable;
  logic            coin_sw;
  logic            busy;
  logic [3:0]      credits;
  logic            dropped;

  modport master (output req, enable, input coin_sw, busy, credits, dropped);
  modport slave  (input req, enable, output coin_sw, busy, credits, dropped);
endinterface

// File: rtl/coin_credit_sequencer.sv
// Debounces coin/start requests, queues them as credits and replays each one
// to the game core as a fixed-width coin_sw pulse followed by a fixed gap.
module coin_credit_sequencer #(
  parameter int NREQ        = 6,
  parameter int DEB_CYC     = 35795,
  parameter int PULSE_CYC   = 357950,
  parameter int GAP_CYC     = 715900,
  parameter int MAX_CREDITS = 9
) (
  input  logic                   clk_sys,
  input  logic                   reset,
  coin_credit_sequencer_if.slave bus
);

  localparam int DEB_W   = 20;
  localparam int TMR_MAX = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_PULSE, S_GAP} state_t;

  logic [NREQ-1:0]  r_deb;
  logic [NREQ-1:0]  r_event;
  logic [DEB_W-1:0] r_deb_cnt [NREQ];

  state_t           r_state;
  logic [TMR_W-1:0] r_tmr;
  logic             r_coin;
  logic             r_busy;
  logic [3:0]       r_credits;
  logic             r_dropped;

  logic [4:0]       w_n;
  logic             w_take;
  logic [4:0]       w_sum;

  // Per-bit debounce; r_event marks a debounced rising edge for one cycle.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_deb   <= '0;
      r_event <= '0;
      // NOTE: the debounce counters are ordinary flops, not a RAM, so they are
      // cleared in the reset loop just like any other state register.
      for (int i = 0; i < NREQ; i++) r_deb_cnt[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples the
      // pre-edge values, independent of statement order.
      for (int i = 0; i < NREQ; i++) begin
        r_event[i] <= 1'b0;
        if (bus.req[i] == r_deb[i]) begin
          r_deb_cnt[i] <= '0;
        end else if (r_deb_cnt[i] == DEB_W'(DEB_CYC - 1)) begin
          r_deb[i]     <= bus.req[i];
          r_event[i]   <= bus.req[i];
          r_deb_cnt[i] <= '0;
        end else begin
          r_deb_cnt[i] <= r_deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave a value held, which would otherwise infer a latch.
    w_n = '0;
    if (bus.enable) begin
      for (int i = 0; i < NREQ; i++) w_n = w_n + 5'(r_event[i]);
    end
    w_take = (r_credits != 4'd0) &&
             ((r_state == S_IDLE) || (r_state == S_GAP && r_tmr == '0));
    w_sum  = 5'(r_credits) + w_n - 5'(w_take);
  end

  // Credit queue and pulse/gap sequencer; a GAP that ends with credits
  // pending goes straight back to PULSE, so back-to-back period is P+G.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_tmr     <= '0;
      r_coin    <= 1'b0;
      r_busy    <= 1'b0;
      r_credits <= '0;
      r_dropped <= 1'b0;
    end else begin
      r_dropped <= (w_sum > 5'(MAX_CREDITS));
      r_credits <= (w_sum > 5'(MAX_CREDITS)) ? 4'(MAX_CREDITS) : w_sum[3:0];
      case (r_state)
        S_IDLE: begin
          if (w_take) begin
            r_state <= S_PULSE;
            r_tmr   <= TMR_W'(PULSE_CYC - 1);
            r_coin  <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        S_PULSE: begin
          if (r_tmr == '0) begin
            r_state <= S_GAP;
            r_tmr   <= TMR_W'(GAP_CYC - 1);
            r_coin  <= 1'b0;
          end else begin
            r_tmr <= r_tmr - 1'b1;
          end
        end
        S_GAP: begin
          if (r_tmr != '0) begin
            r_tmr <= r_tmr - 1'b1;
          end else if (w_take) begin
            r_state <= S_PULSE;
            r_tmr   <= TMR_W'(PULSE_CYC - 1);
            r_coin  <= 1'b1;
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_coin  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.coin_sw = r_coin;
  assign bus.busy    = r_busy;
  assign bus.credits = r_credits;
  assign bus.dropped = r_dropped;

endmodule

// File: tb/tb_coin_credit_sequencer.sv
// Checks coin_credit_sequencer against a timeline-based credit model, with
// directed scenarios pinned by literal expectations plus a random soak.
module tb_coin_credit_sequencer;

  localparam int NR = 6;
  localparam int D  = 2;
  localparam int P  = 4;
  localparam int G  = 3;
  localparam int M  = 3;

  logic clk;
  logic reset;

  coin_credit_sequencer_if #(.NREQ(NR)) bus ();

  coin_credit_sequencer #(
    .NREQ(NR), .DEB_CYC(D), .PULSE_CYC(P), .GAP_CYC(G), .MAX_CREDITS(M)
  ) dut (
    .clk_sys(clk),
    .reset  (reset),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: raw sample history per request, credit count, and pulse timeline
  // expressed as the edge number of the last credit taken.
  int          edge_no = 0;
  bit          model_ok = 0;
  bit [D-1:0]  m_samp [NR];
  bit [NR-1:0] m_deb, m_ev;
  int          m_cred, m_last, m_ready;
  bit          m_drop, m_coin, m_busy;

  always @(posedge clk) begin
    int  n, sum;
    bit  take;
    bit [NR-1:0] new_ev;
    edge_no++;
    if (reset) begin
      for (int i = 0; i < NR; i++) m_samp[i] = '0;
      m_deb = '0; m_ev = '0; m_cred = 0; m_drop = 0;
      m_last = -1000; m_ready = 0; model_ok = 1;
    end else begin
      n    = bus.enable ? $countones(m_ev) : 0;
      take = (m_cred > 0) && (edge_no >= m_ready);
      sum  = m_cred + n - int'(take);
      m_drop = (sum > M);
      m_cred = (sum > M) ? M : sum;
      if (take) begin
        m_last  = edge_no;
        m_ready = edge_no + P + G;
      end
      new_ev = '0;
      for (int i = 0; i < NR; i++) begin
        m_samp[i] = (m_samp[i] << 1) | D'(bus.req[i]);
        if (m_samp[i] == {D{~m_deb[i]}}) begin
          new_ev[i] = ~m_deb[i];
          m_deb[i]  = ~m_deb[i];
        end
      end
      m_ev = new_ev;
    end
    m_coin = (edge_no - m_last) < P;
    m_busy = (edge_no - m_last) < (P + G);
  end

  always @(negedge clk) begin
    if (model_ok) begin
      check("coin_sw", 32'(bus.coin_sw), 32'(m_coin));
      check("busy",    32'(bus.busy),    32'(m_busy));
      check("credits", 32'(bus.credits), 32'(m_cred));
      check("dropped", 32'(bus.dropped), 32'(m_drop));
    end
  end

  task automatic cyc(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset      = 1'b1;
    bus.req    = '0;
    bus.enable = 1'b1;
    cyc(2);
    reset = 1'b0;
  endtask

  task automatic count_pulses(input int ncyc, output int rises);
    logic prev;
    rises = 0;
    prev  = bus.coin_sw;
    for (int k = 0; k < ncyc; k++) begin
      cyc(1);
      if (bus.coin_sw && !prev) rises++;
      prev = bus.coin_sw;
    end
  endtask

  int rises;
  int first_rise, second_rise;

  initial begin
    reset      = 1'b1;
    bus.req    = '0;
    bus.enable = 1'b1;
    cyc(3);
    check("reset_coin",    32'(bus.coin_sw), 0);
    check("reset_busy",    32'(bus.busy),    0);
    check("reset_credits", 32'(bus.credits), 0);
    check("reset_dropped", 32'(bus.dropped), 0);
    reset = 1'b0;

    // Single held request: latency and pulse/gap timing.
    bus.req[0] = 1'b1;                 // first sampled on edge N
    cyc(3);                            // after N+2
    check("t1_credits_n2", 32'(bus.credits), 1);
    check("t1_model_n2",   32'(m_cred), 1);
    check("t1_coin_n2",    32'(bus.coin_sw), 0);
    cyc(1);                            // after N+3
    check("t1_coin_n3",    32'(bus.coin_sw), 1);
    check("t1_credits_n3", 32'(bus.credits), 0);
    check("t1_busy_n3",    32'(bus.busy), 1);
    cyc(3);                            // after N+6
    check("t1_coin_n6",    32'(bus.coin_sw), 1);
    cyc(1);                            // after N+7
    check("t1_coin_n7",    32'(bus.coin_sw), 0);
    check("t1_busy_n7",    32'(bus.busy), 1);
    cyc(2);                            // after N+9
    check("t1_busy_n9",    32'(bus.busy), 1);
    cyc(1);                            // after N+10
    check("t1_busy_n10",   32'(bus.busy), 0);
    check("t1_model_busy", 32'(m_busy), 0);
    bus.req[0] = 1'b0;
    cyc(10);

    // One-cycle glitch never produces a credit.
    bus.req[2] = 1'b1;
    cyc(1);
    bus.req[2] = 1'b0;
    for (int k = 0; k < 50; k++) begin
      cyc(1);
      check("t2_coin",    32'(bus.coin_sw), 0);
      check("t2_credits", 32'(bus.credits), 0);
      check("t2_dropped", 32'(bus.dropped), 0);
    end

    // Two simultaneous requests: two pulses 7 cycles apart.
    do_reset();
    bus.req[1] = 1'b1;
    bus.req[3] = 1'b1;
    cyc(3);
    check("t3_credits", 32'(bus.credits), 2);
    first_rise = -1; second_rise = -1;
    for (int k = 1; k <= 30; k++) begin
      cyc(1);
      if (bus.coin_sw && first_rise < 0) first_rise = k;
      else if (bus.coin_sw && first_rise >= 0 && second_rise < 0 && k > first_rise + P)
        second_rise = k;
    end
    check("t3_first_rise", 32'(first_rise), 1);
    check("t3_period",     32'(second_rise - first_rise), P + G);
    check("t3_credits_end", 32'(bus.credits), 0);
    bus.req = '0;
    cyc(5);

    // Saturation: five simultaneous credits into a queue of three.
    do_reset();
    bus.req[4:0] = 5'h1f;
    cyc(3);
    check("t4_credits_sat", 32'(bus.credits), M);
    check("t4_dropped",     32'(bus.dropped), 1);
    count_pulses(30, rises);
    check("t4_pulses", 32'(rises), M);
    bus.req = '0;
    cyc(5);

    // enable=0 discards new events but queued credits still replay.
    do_reset();
    bus.req[0] = 1'b1;
    cyc(3);
    check("t5_credits_pre", 32'(bus.credits), 1);
    bus.enable = 1'b0;
    bus.req[4] = 1'b1;
    count_pulses(30, rises);
    bus.enable = 1'b1;
    count_pulses(20, first_rise);
    check("t5_pulses",      32'(rises + first_rise), 1);
    check("t5_credits_end", 32'(bus.credits), 0);
    bus.req = '0;
    cyc(5);

    // Reset during a pulse with two credits queued.
    do_reset();
    bus.req[2:0] = 3'h7;
    cyc(4);
    check("t6_coin_pre",    32'(bus.coin_sw), 1);
    check("t6_credits_pre", 32'(bus.credits), 2);
    cyc(1);
    reset   = 1'b1;
    bus.req = '0;
    cyc(1);
    check("t6_coin_rst",    32'(bus.coin_sw), 0);
    check("t6_credits_rst", 32'(bus.credits), 0);
    check("t6_busy_rst",    32'(bus.busy), 0);
    reset = 1'b0;
    count_pulses(30, rises);
    check("t6_no_pulses", 32'(rises), 0);

    // Random soak: toggling requests with variable hold, enable and resets.
    do_reset();
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      for (int i = 0; i < NR; i++)
        if ($urandom_range(11) == 0) bus.req[i] = ~bus.req[i];
      if ($urandom_range(63) == 0) bus.enable = ~bus.enable;
      reset = ($urandom_range(599) == 0);
    end
    reset = 1'b0;
    bus.req = '0;
    cyc(60);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
